// File: rtl/tx_fifo_pkg.sv
// Shared widths and the block-to-word slicing rule for the transmit FIFO.
// Words leave a block most-significant first.
package tx_fifo_pkg;

    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 128;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int WIDX_W          = $clog2(WORDS_PER_BLOCK);

    // Index 0 is the top word of the block, index 3 the bottom word.
    function automatic logic [WORD_W-1:0] word_slice(input logic [BLOCK_W-1:0] blk,
                                                     input logic [WIDX_W-1:0]  idx);
        word_slice = blk[(BLOCK_W - 1) - (WORD_W * int'(idx)) -: WORD_W];
    endfunction

endpackage

// File: rtl/tx_fifo_if.sv
// Engine/AHB-side bundle of the transmit FIFO.
// The master drives the requests; the slave (the FIFO) returns data and status.
interface tx_fifo_if
    import tx_fifo_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic               tx_enq;
    logic [BLOCK_W-1:0] tx_block;
    logic               tx_deq_word;
    logic               flush;
    logic               clr_error;
    logic [WORD_W-1:0]  tx_fifo_out;
    logic               full;
    logic               empty;
    logic [CW-1:0]      tx_count;
    logic               overflow;
    logic               underrun;

    modport master (
        output tx_enq, tx_block, tx_deq_word, flush, clr_error,
        input  tx_fifo_out, full, empty, tx_count, overflow, underrun
    );

    modport slave (
        input  tx_enq, tx_block, tx_deq_word, flush, clr_error,
        output tx_fifo_out, full, empty, tx_count, overflow, underrun
    );

endinterface

// File: rtl/tx_ptr_counter.sv
// Wrapping pointer with a wrap-toggle bit, enable and synchronous clear.
// 'wrap' is a combinational pulse for the cycle that rolls the pointer over.
module tx_ptr_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] ptr,
    output logic         tog,
    output logic         wrap
);

    assign wrap = en && (ptr == '1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
            tog <= 1'b0;
        end else if (en) begin
            ptr <= ptr + 1'b1;
            if (wrap) tog <= ~tog;
        end
    end

endmodule

// File: rtl/tx_fifo.sv
// Transmit block buffer: 128-bit blocks in, one 32-bit word out per dequeue.
// Full/empty come from extended pointers; overflow/underrun are sticky.
module tx_fifo
    import tx_fifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic     clk,
    input logic     rst,
    tx_fifo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [BLOCK_W-1:0] mem [DEPTH];

    logic [AW-1:0]     head, tail;
    logic              head_tog, tail_tog;
    logic [WIDX_W-1:0] word_idx;
    logic              word_wrap, head_wrap_unused, tail_wrap_unused, word_tog_unused;
    logic              is_empty, is_full;
    logic              enq_ok, deq_ok, ovf_set, unr_set;

    assign is_empty = (head == tail) && (head_tog == tail_tog);
    assign is_full  = (head == tail) && (head_tog != tail_tog);

    // Flush discards the request of that cycle entirely, including its error.
    assign enq_ok  = bus.tx_enq      && !is_full  && !bus.flush;
    assign deq_ok  = bus.tx_deq_word && !is_empty && !bus.flush;
    assign ovf_set = bus.tx_enq      &&  is_full  && !bus.flush;
    assign unr_set = bus.tx_deq_word &&  is_empty && !bus.flush;

    tx_ptr_counter #(.W(AW)) u_tail (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.flush),
        .en   (enq_ok),
        .ptr  (tail),
        .tog  (tail_tog),
        .wrap (tail_wrap_unused)
    );

    tx_ptr_counter #(.W(WIDX_W)) u_word (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.flush),
        .en   (deq_ok),
        .ptr  (word_idx),
        .tog  (word_tog_unused),
        .wrap (word_wrap)
    );

    // The head block retires on the dequeue of its last word.
    tx_ptr_counter #(.W(AW)) u_head (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.flush),
        .en   (word_wrap),
        .ptr  (head),
        .tog  (head_tog),
        .wrap (head_wrap_unused)
    );

    always_ff @(posedge clk) begin
        if (enq_ok) mem[tail] <= bus.tx_block;
    end

    // A fresh error outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.overflow <= 1'b0;
            bus.underrun <= 1'b0;
        end else begin
            if (ovf_set)            bus.overflow <= 1'b1;
            else if (bus.clr_error) bus.overflow <= 1'b0;
            if (unr_set)            bus.underrun <= 1'b1;
            else if (bus.clr_error) bus.underrun <= 1'b0;
        end
    end

    assign bus.empty       = is_empty;
    assign bus.full        = is_full;
    assign bus.tx_count    = {tail_tog, tail} - {head_tog, head};
    assign bus.tx_fifo_out = is_empty ? '0 : word_slice(mem[head], word_idx);

endmodule

// File: tb/tb_tx_fifo.sv
// Bench for tx_fifo: directed vector table, then random traffic against a queue model.
module tb_tx_fifo;

    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        bit           enq;
        logic [127:0] blk;
        bit           deq;
        bit           fl;
        bit           clr;
        bit           r;
        logic [31:0]  exp_out;
        bit           exp_empty;
        bit           exp_full;
        int           exp_count;
        bit           exp_ovf;
        bit           exp_unr;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int errors = 0;

    logic [127:0] mq[$];
    int           m_idx = 0;
    bit           m_ovf = 0;
    bit           m_unr = 0;

    function automatic logic [31:0] mkW(input int k, input int w);
        return 32'hB000_0000 | (32'(k) << 8) | 32'(w);
    endfunction

    function automatic logic [127:0] mkB(input int k);
        return {mkW(k, 0), mkW(k, 1), mkW(k, 2), mkW(k, 3)};
    endfunction

    function automatic void addVec(input string nm, input bit enq, input logic [127:0] blk,
                                   input bit deq, input bit fl, input bit clr, input bit r,
                                   input logic [31:0] eo, input bit ee, input bit ef,
                                   input int ec, input bit eov, input bit eun);
        vec_t v;
        v.name = nm; v.enq = enq; v.blk = blk; v.deq = deq; v.fl = fl; v.clr = clr; v.r = r;
        v.exp_out = eo; v.exp_empty = ee; v.exp_full = ef; v.exp_count = ec;
        v.exp_ovf = eov; v.exp_unr = eun;
        vecs.push_back(v);
    endfunction

    // Behavioural reference: a queue of whole blocks plus a word position in the head block.
    task automatic modelStep(input bit enq, input logic [127:0] blk, input bit deq,
                             input bit fl, input bit clr, input bit r);
        bit was_full, was_empty, new_ovf, new_unr;
        new_ovf = 0;
        new_unr = 0;
        if (r) begin
            mq.delete();
            m_idx = 0;
            m_ovf = 0;
            m_unr = 0;
        end else begin
            if (fl) begin
                mq.delete();
                m_idx = 0;
            end else begin
                was_full  = (mq.size() == DEPTH);
                was_empty = (mq.size() == 0);
                new_ovf   = enq && was_full;
                new_unr   = deq && was_empty;
                if (deq && !was_empty) begin
                    m_idx++;
                    if (m_idx == 4) begin
                        m_idx = 0;
                        void'(mq.pop_front());
                    end
                end
                if (enq && !was_full) mq.push_back(blk);
            end
            m_ovf = new_ovf ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_unr = new_unr ? 1'b1 : (clr ? 1'b0 : m_unr);
        end
    endtask

    function automatic logic [31:0] modelWord();
        logic [127:0] tmp;
        if (mq.size() == 0) return 32'h0;
        tmp = mq[0];
        return 32'(tmp >> (32 * (3 - m_idx)));
    endfunction

    task automatic applyStimulus(input bit enq, input logic [127:0] blk, input bit deq,
                                 input bit fl, input bit clr, input bit r);
        bus.tx_enq      = enq;
        bus.tx_block    = blk;
        bus.tx_deq_word = deq;
        bus.flush       = fl;
        bus.clr_error   = clr;
        rst             = r;
        @(posedge clk);
        modelStep(enq, blk, deq, fl, clr, r);
        #1;
    endtask

    task automatic checkOutput(input string nm, input logic [31:0] eo, input bit ee,
                               input bit ef, input int ec, input bit eov, input bit eun);
        checks++;
        if (bus.tx_fifo_out !== eo || bus.empty !== ee || bus.full !== ef ||
            int'(bus.tx_count) != ec || bus.overflow !== eov || bus.underrun !== eun) begin
            errors++;
            $display("[TB] FAIL %s: got out=%h empty=%b full=%b count=%0d ovf=%b unr=%b, want out=%h empty=%b full=%b count=%0d ovf=%b unr=%b",
                     nm, bus.tx_fifo_out, bus.empty, bus.full, bus.tx_count, bus.overflow,
                     bus.underrun, eo, ee, ef, ec, eov, eun);
        end
    endtask

    initial begin
        logic [127:0] b0;
        int cnt;
        logic [31:0] eo;
        b0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

        bus.tx_enq = 0; bus.tx_block = '0; bus.tx_deq_word = 0;
        bus.flush = 0; bus.clr_error = 0; rst = 1;

        addVec("reset",       0, '0, 0, 0, 0, 1, 32'h0,        1, 0, 0, 0, 0);
        addVec("enq_b0",      1, b0, 0, 0, 0, 0, 32'h00112233, 0, 0, 1, 0, 0);
        addVec("deq_w1",      0, '0, 1, 0, 0, 0, 32'h44556677, 0, 0, 1, 0, 0);
        addVec("deq_w2",      0, '0, 1, 0, 0, 0, 32'h8899AABB, 0, 0, 1, 0, 0);
        addVec("deq_w3",      0, '0, 1, 0, 0, 0, 32'hCCDDEEFF, 0, 0, 1, 0, 0);
        addVec("deq_empty",   0, '0, 1, 0, 0, 0, 32'h0,        1, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++)
            addVec($sformatf("fill_%0d", k), 1, mkB(k), 0, 0, 0, 0, mkW(1, 0), 0, k == 4, k, 0, 0);
        addVec("enq_full",    1, mkB(5), 0, 0, 0, 0, mkW(1, 0), 0, 1, 4, 1, 0);
        for (int k = 1; k <= 4; k++) begin
            for (int w = 0; w < 4; w++) begin
                cnt = (w == 3) ? 4 - k : 5 - k;
                eo  = (w < 3) ? mkW(k, w + 1) : ((k < 4) ? mkW(k + 1, 0) : 32'h0);
                addVec($sformatf("drain_%0d_%0d", k, w), 0, '0, 1, 0, 0, 0, eo,
                       cnt == 0, cnt == 4, cnt, 1, 0);
            end
        end
        addVec("clr_ovf",     0, '0, 0, 0, 1, 0, 32'h0,        1, 0, 0, 0, 0);
        for (int k = 6; k <= 9; k++)
            addVec($sformatf("refill_%0d", k), 1, mkB(k), 0, 0, 0, 0, mkW(6, 0), 0, k == 9, k - 5, 0, 0);
        for (int w = 1; w <= 3; w++)
            addVec($sformatf("part_%0d", w), 0, '0, 1, 0, 0, 0, mkW(6, w), 0, 1, 4, 0, 0);
        addVec("full_last_enq_deq", 1, mkB(10), 1, 0, 0, 0, mkW(7, 0), 0, 0, 3, 1, 0);
        addVec("flush_keeps_ovf",   0, '0, 0, 1, 0, 0, 32'h0,     1, 0, 0, 1, 0);
        addVec("clr_ovf2",          0, '0, 0, 0, 1, 0, 32'h0,     1, 0, 0, 0, 0);
        addVec("empty_enq_deq",     1, mkB(11), 1, 0, 0, 0, mkW(11, 0), 0, 0, 1, 0, 1);
        addVec("flush_keeps_unr",   0, '0, 0, 1, 0, 0, 32'h0,     1, 0, 0, 0, 1);
        addVec("clr_vs_new_unr",    0, '0, 1, 0, 1, 0, 32'h0,     1, 0, 0, 0, 1);
        addVec("clr_unr",           0, '0, 0, 0, 1, 0, 32'h0,     1, 0, 0, 0, 0);
        addVec("ft_enq12",          1, mkB(12), 0, 0, 0, 0, mkW(12, 0), 0, 0, 1, 0, 0);
        addVec("ft_enq13",          1, mkB(13), 0, 0, 0, 0, mkW(12, 0), 0, 0, 2, 0, 0);
        addVec("ft_deq1",           0, '0, 1, 0, 0, 0, mkW(12, 1), 0, 0, 2, 0, 0);
        addVec("ft_deq2",           0, '0, 1, 0, 0, 0, mkW(12, 2), 0, 0, 2, 0, 0);
        addVec("flush_with_enq",    1, mkB(14), 0, 1, 0, 0, 32'h0, 1, 0, 0, 0, 0);
        for (int k = 15; k <= 17; k++)
            addVec($sformatf("rt_enq%0d", k), 1, mkB(k), 0, 0, 0, 0, mkW(15, 0), 0, 0, k - 14, 0, 0);
        addVec("rt_deq1",           0, '0, 1, 0, 0, 0, mkW(15, 1), 0, 0, 3, 0, 0);
        addVec("rt_deq2",           0, '0, 1, 0, 0, 0, mkW(15, 2), 0, 0, 3, 0, 0);
        addVec("reset_mid_drain",   0, '0, 0, 0, 0, 1, 32'h0,     1, 0, 0, 0, 0);
        addVec("enq_after_reset",   1, mkB(18), 0, 0, 0, 0, mkW(18, 0), 0, 0, 1, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].enq, vecs[i].blk, vecs[i].deq, vecs[i].fl, vecs[i].clr, vecs[i].r);
            checkOutput(vecs[i].name, vecs[i].exp_out, vecs[i].exp_empty, vecs[i].exp_full,
                        vecs[i].exp_count, vecs[i].exp_ovf, vecs[i].exp_unr);
        end

        for (int n = 0; n < 3000; n++) begin
            logic [127:0] rb;
            rb = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus($urandom_range(99) < 50, rb, $urandom_range(99) < 65,
                          $urandom_range(99) < 3, $urandom_range(99) < 6, $urandom_range(199) == 0);
            checkOutput($sformatf("rand_%0d", n), modelWord(), mq.size() == 0,
                        mq.size() == DEPTH, mq.size(), m_ovf, m_unr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_fifo.md
# tx_fifo

Transmit-side block buffer for the slave datapath. Accepts 128-bit result blocks from the engine in a single cycle and serves them to the AHB read path one 32-bit word at a time. It is the read-out counterpart of the receive FIFO, which packs bus words into blocks. Full, empty and sticky error flags go to the slave control FSM and status register.

## Interface
- DEPTH, 4: number of 128-bit block entries; power of two, at least 2.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- tx_enq  in  1  push `tx_block` into the tail entry this cycle.
- tx_block  in  128  result block from the engine.
- tx_deq_word  in  1  pop the current head word; the AHB side has consumed `tx_fifo_out`.
- flush  in  1  discard all contents.
- clr_error  in  1  clear both sticky error flags.
- tx_fifo_out  out  32  current head word; valid only while `empty` is 0.
- full  out  1  all DEPTH entries hold unread blocks.
- empty  out  1  no unread block.
- tx_count  out  $clog2(DEPTH)+1  number of blocks held, 0..DEPTH.
- overflow  out  1  sticky; `tx_enq` was asserted while `full` was 1.
- underrun  out  1  sticky; `tx_deq_word` was asserted while `empty` was 1.

## Operation
- Storage is DEPTH×128-bit registers.
- Pointers:
  - `head` and `tail` are each $clog2(DEPTH) bits, with a wrap-toggle bit.
  - `word_idx` is a 2-bit index into the head block.
- `empty` = (head==tail) && (head_tog==tail_tog). `full` = (head==tail) && (head_tog!=tail_tog). Both are derived from registered state only.
- Enqueue: when `tx_enq` && !full, write `tx_block` to entry[tail] and advance tail. Wrapping from DEPTH-1 to 0 flips tail_tog.
- Word order is most-significant first:
  - `word_idx` 0 selects [127:96], 1 selects [95:64], 2 selects [63:32], 3 selects [31:0].
  - `tx_fifo_out` = entry[head] slice at `word_idx`. It is combinational from registers and drives 0 when empty.
- Dequeue (`tx_deq_word` && !empty):
  - `word_idx` increments.
  - At `word_idx`==3 it wraps to 0, head advances, and head_tog flips on wrap.
- Rejected operations: enqueue while full is dropped and sets `overflow`; word dequeue while empty is ignored and sets `underrun`. Storage and pointers are unchanged.
- Simultaneous enqueue and dequeue:
  - Each side is evaluated against the pre-edge `full`/`empty`.
  - Enqueue while full together with the last-word dequeue: the dequeue completes, the enqueue is dropped, and `overflow` is set.
  - Dequeue while empty together with an enqueue: the enqueue completes, the dequeue is ignored, and `underrun` is set.
- `tx_count` = tail − head over the extended pointers, computed mod 2·DEPTH.
- `flush`:
  - Zeroes head, tail, toggles and `word_idx` next cycle. Block data is not cleared.
  - Takes priority over `tx_enq`/`tx_deq_word` in the same cycle; those operations are discarded and set no error.
  - Does not clear the error flags.
- Error flags: `clr_error` clears both. A new error in the same cycle as `clr_error` wins, and the flag stays 1.

## Timing
- Reset values: pointers, toggles and `word_idx` are 0. Outputs: `empty`=1, `full`=0, `tx_count`=0, `overflow`=0, `underrun`=0, `tx_fifo_out`=0. Storage is not reset.
- Reset mid-drain has the same effect as reset from idle: the partial block is lost.
- Enqueue latency: `tx_enq` at edge N gives `empty`=0 and a valid `tx_fifo_out` after edge N. No bypass from `tx_block` to the output.
- Word advance: `tx_fifo_out` shows the next word in the cycle after the `tx_deq_word` edge. A block drains in 4 consecutive dequeue cycles at full rate.
- `full` and `tx_count` update in the cycle after the enqueue or block retire that changes them.
- Back-to-back enqueue is allowed every cycle until full.

## Structure
- Package `tx_fifo_pkg` holds:
  - WORD_W=32, BLOCK_W=128, WORDS_PER_BLOCK=4.
  - The word-slice function mapping `word_idx` to the bit range.
- Sub-module `tx_ptr_counter` is a wrapping pointer with toggle, enable and sync clear.
  - Instantiated for head and tail.
  - `word_idx` is a 2-bit instance with its wrap pulse driving the head enable.

## Test plan
- Reset, then enqueue block 0x00112233_44556677_8899AABB_CCDDEEFF → next cycle `tx_fifo_out`=0x00112233 and `empty`=0. Four dequeues yield 0x44556677, 0x8899AABB, 0xCCDDEEFF, then `empty`=1.
- Enqueue 4 blocks → `full`=1 and `tx_count`=4. A 5th enqueue → `overflow`=1 and contents unchanged. Drain 16 words → order intact, including wrap of head and tail.
- With `full`=1 and `word_idx`=3, assert enqueue and dequeue together → block retired, new block dropped, `overflow`=1, `tx_count`=3.
- With `empty`=1, assert enqueue and dequeue together → `tx_count`=1, `word_idx`=0, `underrun`=1. Then `clr_error` plus another dequeue-while-empty in the same cycle → `underrun` stays 1.
- Enqueue 2 blocks, dequeue 2 words, assert `flush` together with `tx_enq` → next cycle `empty`=1, `tx_count`=0, no error flag set.
- Assert `rst` mid-drain with 3 blocks held → next cycle all outputs are at their reset values.
